skinscore_packer: RTL

- Sits directly downstream of the skin-tone datapath.
- Consumes its 8-bit per-pixel skin scores, which arrive with a valid strobe and cannot be stalled.
- Packs four scores into one 32-bit word and buffers the words in a small FIFO.
- Presents the words to the memory/bus writer through a valid/ready handshake, and returns a throttle hint upstream so the pixel source stops issuing pixels before in-flight scores can overflow the buffer.

---
 rtl/skinscore_packer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/skinscore_packer.sv
// Packs 8-bit skin scores four per 32-bit word into a fall-through FIFO; a word is visible the cycle after its committing score.
// Scores cannot be stalled: a registered upstream_ready throttles the source, and a word that still meets a full FIFO is dropped and flagged.

module skinscore_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_vld_i,
   input  logic [W-1:0]               push_dat_i,
   output logic                       drop_o,
   output logic                       pop_vld_o,
   input  logic                       pop_rdy_i,
   output logic [W-1:0]               pop_dat_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [$clog2(DEPTH):0]     level_nxt_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          pop, full, push_ok;

   // A pop frees the slot at the same edge, so a full FIFO can still take a word.
   always_comb begin
      pop      = (level_q != '0) && pop_rdy_i;
      full     = (level_q == (AW+1)'(DEPTH));
      push_ok  = push_vld_i && (!full || pop);
      drop_o   = push_vld_i && full && !pop;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (push_ok && !pop)
         level_d = level_q + (AW+1)'(1);
      else if (!push_ok && pop)
         level_d = level_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign pop_vld_o   = (level_q != '0);
   assign pop_dat_o   = pop_vld_o ? mem_q[rd_ptr_q] : '0;
   assign level_o     = level_q;
   assign level_nxt_o = level_d;
endmodule

module skinscore_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int SKID       = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    score_in,
   input  logic                          score_in_valid,
   input  logic                          score_in_last,
   output logic                          upstream_ready,
   output logic [31:0]                   word_out,
   output logic [3:0]                    word_out_keep,
   output logic                          word_out_last,
   output logic                          word_out_valid,
   input  logic                          word_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);
   typedef enum logic [1:0] {LANE0, LANE1, LANE2, LANE3} lane_e;

   typedef struct packed {
      logic        last;
      logic [3:0]  keep;
      logic [31:0] data;
   } word_t;

   lane_e       lane_q, lane_d;
   logic [31:0] asm_q, asm_d;
   logic        overflow_q, overflow_d;
   logic        uready_q, uready_d;
   logic        commit, drop, head_vld;
   word_t       commit_word, head_word;
   logic [3:0]  keep_now;
   logic [$clog2(FIFO_DEPTH):0] level, level_nxt;

   always_comb begin
      lane_d           = lane_q;
      asm_d            = asm_q;
      commit           = 1'b0;
      keep_now         = 4'b0001;
      commit_word.data = asm_q | (32'(score_in) << {lane_q, 3'b000});
      commit_word.last = score_in_last;
      case (lane_q)
         LANE0:   keep_now = 4'b0001;
         LANE1:   keep_now = 4'b0011;
         LANE2:   keep_now = 4'b0111;
         default: keep_now = 4'b1111;
      endcase
      commit_word.keep = keep_now;
      if (score_in_valid) begin
         if (lane_q == LANE3 || score_in_last) begin
            commit = 1'b1;
            lane_d = LANE0;
            asm_d  = '0;
         end else begin
            asm_d = commit_word.data;
            case (lane_q)
               LANE0:   lane_d = LANE1;
               LANE1:   lane_d = LANE2;
               default: lane_d = LANE3;
            endcase
         end
      end
   end

   skinscore_fifo #(
      .W     ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .push_vld_i  (commit),
      .push_dat_i  (commit_word),
      .drop_o      (drop),
      .pop_vld_o   (head_vld),
      .pop_rdy_i   (word_out_ready),
      .pop_dat_o   (head_word),
      .level_o     (level),
      .level_nxt_o (level_nxt)
   );

   // Throttle leaves room for the scores still travelling through the datapath.
   always_comb begin
      overflow_d = overflow_q | drop;
      uready_d   = ((FIFO_DEPTH - int'(level_nxt)) > SKID);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q     <= LANE0;
         asm_q      <= '0;
         overflow_q <= 1'b0;
         uready_q   <= 1'b1;
      end else begin
         lane_q     <= lane_d;
         asm_q      <= asm_d;
         overflow_q <= overflow_d;
         uready_q   <= uready_d;
      end
   end

   assign upstream_ready = uready_q;
   assign overflow       = overflow_q;
   assign fifo_level     = level;
   assign word_out_valid = head_vld;
   assign word_out       = head_word.data;
   assign word_out_keep  = head_word.keep;
   assign word_out_last  = head_word.last;
endmodule
